floor_request_scheduler: RTL and testbench

FLOOR_REQUEST_SCHEDULER -- requirements
Module: floor_request_scheduler

---
 rtl/escalator_pkg.sv | 44 ++++
 rtl/call_sync_edge.sv | 48 ++++
 rtl/floor_request_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_floor_request_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/escalator_pkg.sv
// Shared definitions for the four-floor call scheduler: floor encodings,
// FSM state type and small one-hot helpers.
package escalator_pkg;

  localparam int NUM_FLOORS = 4;

  localparam logic [NUM_FLOORS-1:0] FLOOR_0 = 4'b0001;
  localparam logic [NUM_FLOORS-1:0] FLOOR_1 = 4'b0010;
  localparam logic [NUM_FLOORS-1:0] FLOOR_2 = 4'b0100;
  localparam logic [NUM_FLOORS-1:0] FLOOR_3 = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR      = 2'd3
  } state_e;

  // True when exactly one bit is set.
  function automatic logic is_one_hot(input logic [NUM_FLOORS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Isolates the lowest set bit (nearest floor above when applied to an above-mask).
  function automatic logic [NUM_FLOORS-1:0] lowest_bit(input logic [NUM_FLOORS-1:0] v);
    return v & (~v + 1'b1);
  endfunction

  // Isolates the highest set bit (nearest floor below when applied to a below-mask).
  function automatic logic [NUM_FLOORS-1:0] highest_bit(input logic [NUM_FLOORS-1:0] v);
    logic [NUM_FLOORS-1:0] r;
    logic                  found;
    r     = '0;
    found = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/call_sync_edge.sv
// Multi-stage synchronizer for the raw call buttons followed by a rising-edge
// detector. Edges are suppressed until the chain has been refilled with real
// pin samples after reset, so a button held through reset release does not
// register until it is released and pressed again.
module call_sync_edge
  import escalator_pkg::*;
#(
  parameter int WIDTH       = NUM_FLOORS,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     prev_q;
  logic [SYNC_STAGES:0] fill_q;
  logic [WIDTH-1:0]     sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Shift the pins through the synchronizer, keep last value for edge detect,
  // and track how many real samples have entered since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_last;
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Per-bit rising edge, qualified once both compared samples are real pin values.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
    assign rise_o[gi] = fill_q[SYNC_STAGES] & sync_last[gi] & ~prev_q[gi];
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// Four-floor call scheduler: latches call-button presses, chooses a travel
// direction with last-direction preference, holds the door open for a number
// of tick pulses at each served floor, and drives the one-hot target floor.
module floor_request_scheduler
  import escalator_pkg::*;
#(
  parameter int DWELL_TICKS = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [NUM_FLOORS-1:0] present_floor,
  input  logic                  tick,
  output logic [NUM_FLOORS-1:0] requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up,
  output logic                  dir_down
);

  // Dwell completes on the tick that would bring the count to DWELL_TICKS.
  localparam logic [1:0] DWELL_LAST = 2'(DWELL_TICKS - 1);

  state_e                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [1:0]            dwell_q, dwell_d;
  logic                  last_dir_q, last_dir_d;
  logic [NUM_FLOORS-1:0] door_floor_q, door_floor_d;
  logic [NUM_FLOORS-1:0] req_q, req_d;
  logic                  door_q, door_d;
  logic                  up_q, up_d;
  logic                  down_q, down_d;

  logic [NUM_FLOORS-1:0] press_rise;
  logic                  floor_ok;
  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;
  logic                  calls_above;
  logic                  calls_below;
  logic                  at_call;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] next_above;
  logic [NUM_FLOORS-1:0] next_below;

  call_sync_edge #(
    .WIDTH       (NUM_FLOORS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_call_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (call_btn),
    .rise_o  (press_rise)
  );

  // Floors strictly above / below the current position, from the one-hot code.
  assign floor_ok    = is_one_hot(present_floor);
  assign above_mask  = ~((present_floor << 1) - 1'b1);
  assign below_mask  = present_floor - 1'b1;
  assign calls_above = |(pending_q & above_mask);
  assign calls_below = |(pending_q & below_mask);
  assign at_call     = |(pending_q & present_floor);
  assign next_above  = pending_d & above_mask;
  assign next_below  = pending_d & below_mask;

  // Next-state, call bookkeeping and next output values.
  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    door_floor_d = door_floor_q;
    clr_mask     = '0;

    if (!floor_ok) begin
      // Position unknown: park in IDLE and never clear a call.
      state_d = ST_IDLE;
      dwell_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (at_call) begin
            state_d      = ST_DOOR;
            dwell_d      = 2'd0;
            door_floor_d = present_floor;
          end else if (calls_above && calls_below) begin
            state_d = last_dir_q ? ST_MOVE_UP : ST_MOVE_DOWN;
          end else if (calls_above) begin
            state_d = ST_MOVE_UP;
          end else if (calls_below) begin
            state_d = ST_MOVE_DOWN;
          end
        end
        ST_MOVE_UP: begin
          if (at_call) begin
            state_d      = ST_DOOR;
            dwell_d      = 2'd0;
            door_floor_d = present_floor;
          end else if (!calls_above) begin
            state_d = ST_IDLE;
          end
        end
        ST_MOVE_DOWN: begin
          if (at_call) begin
            state_d      = ST_DOOR;
            dwell_d      = 2'd0;
            door_floor_d = present_floor;
          end else if (!calls_below) begin
            state_d = ST_IDLE;
          end
        end
        ST_DOOR: begin
          // The floor latched on entry is authoritative while the door is open.
          if (|(press_rise & door_floor_q)) begin
            dwell_d = 2'd0;
          end else if (tick) begin
            if (dwell_q == DWELL_LAST) begin
              clr_mask = door_floor_q;
              state_d  = ST_IDLE;
              dwell_d  = 2'd0;
            end else begin
              dwell_d = dwell_q + 2'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          dwell_d = 2'd0;
        end
      endcase
    end

    // A new press always wins over a same-cycle clear.
    pending_d = (pending_q & ~clr_mask) | press_rise;

    case (state_d)
      ST_MOVE_UP:   last_dir_d = 1'b1;
      ST_MOVE_DOWN: last_dir_d = 1'b0;
      default:      last_dir_d = last_dir_q;
    endcase

    if (!floor_ok) begin
      req_d = FLOOR_0;
    end else begin
      case (state_d)
        ST_MOVE_UP:   req_d = lowest_bit(next_above);
        ST_MOVE_DOWN: req_d = highest_bit(next_below);
        ST_DOOR:      req_d = door_floor_d;
        default:      req_d = present_floor;
      endcase
    end

    door_d = (state_d == ST_DOOR);
    up_d   = (state_d == ST_MOVE_UP);
    down_d = (state_d == ST_MOVE_DOWN);
  end

  // State, call latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      dwell_q      <= 2'd0;
      last_dir_q   <= 1'b1;
      door_floor_q <= FLOOR_0;
      req_q        <= FLOOR_0;
      door_q       <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      dwell_q      <= dwell_d;
      last_dir_q   <= last_dir_d;
      door_floor_q <= door_floor_d;
      req_q        <= req_d;
      door_q       <= door_d;
      up_q         <= up_d;
      down_q       <= down_d;
    end
  end

  assign requested_floor = req_q;
  assign pending         = pending_q;
  assign door_open       = door_q;
  assign dir_up          = up_q;
  assign dir_down        = down_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Scoreboard bench for floor_request_scheduler: a floor-index reference model
// pushes expected outputs each clock, a monitor pops and compares them, and
// directed scenarios add explicit spot checks around random traffic.
module tb_floor_request_scheduler;

  localparam int S = 2;
  localparam int D = 3;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] call_btn = 4'b0000;
  logic [3:0] present_floor = 4'b0001;
  logic       tick = 1'b0;
  logic [3:0] requested_floor;
  logic [3:0] pending;
  logic       door_open;
  logic       dir_up;
  logic       dir_down;

  floor_request_scheduler #(.DWELL_TICKS(D), .SYNC_STAGES(S)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .call_btn        (call_btn),
    .present_floor   (present_floor),
    .tick            (tick),
    .requested_floor (requested_floor),
    .pending         (pending),
    .door_open       (door_open),
    .dir_up          (dir_up),
    .dir_down        (dir_down)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] pend;
    logic       door;
    logic       up;
    logic       down;
  } obs_t;

  obs_t exp_q[$];

  // Reference model state, in floor indices.
  int         m_st;
  logic [3:0] m_pend;
  int         m_dwell;
  bit         m_last;
  int         m_dfl;
  logic [3:0] hist[$];

  bit tick_rand = 1'b0;
  bit plant_en = 1'b0;
  int pcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int find_above(input logic [3:0] p, input int pf);
    for (int i = pf + 1; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic int find_below(input logic [3:0] p, input int pf);
    for (int i = pf - 1; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  // Reference model: one step per rising edge, expected outputs queued.
  initial begin
    obs_t o;
    logic [3:0] e;
    int pf, nst, clr;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_st = M_IDLE; m_pend = 4'b0; m_dwell = 0; m_last = 1'b1; m_dfl = 0;
        hist.delete();
        o = '{req: 4'b0001, pend: 4'b0, door: 1'b0, up: 1'b0, down: 1'b0};
      end else begin
        e = 4'b0;
        if (hist.size() >= S + 1)
          e = hist[hist.size() - S] & ~hist[hist.size() - S - 1];
        hist.push_back(call_btn);
        if (hist.size() > S + 2) void'(hist.pop_front());
        pf  = idx_of(present_floor);
        nst = m_st;
        clr = -1;
        if (pf < 0) begin
          nst = M_IDLE; m_dwell = 0;
        end else begin
          case (m_st)
            M_IDLE, M_UP, M_DOWN: begin
              if (m_pend[pf]) begin
                nst = M_DOOR; m_dwell = 0; m_dfl = pf;
              end else if (m_st == M_IDLE) begin
                if (find_above(m_pend, pf) >= 0 && find_below(m_pend, pf) >= 0)
                  nst = m_last ? M_UP : M_DOWN;
                else if (find_above(m_pend, pf) >= 0) nst = M_UP;
                else if (find_below(m_pend, pf) >= 0) nst = M_DOWN;
              end else if (m_st == M_UP && find_above(m_pend, pf) < 0) begin
                nst = M_IDLE;
              end else if (m_st == M_DOWN && find_below(m_pend, pf) < 0) begin
                nst = M_IDLE;
              end
            end
            default: begin
              if (e[m_dfl]) m_dwell = 0;
              else if (tick) begin
                if (m_dwell == D - 1) begin
                  clr = m_dfl; nst = M_IDLE; m_dwell = 0;
                end else m_dwell++;
              end
            end
          endcase
        end
        if (clr >= 0) m_pend[clr] = 1'b0;
        m_pend = m_pend | e;
        m_st = nst;
        if (m_st == M_UP) m_last = 1'b1;
        if (m_st == M_DOWN) m_last = 1'b0;
        o.pend = m_pend;
        o.door = (m_st == M_DOOR);
        o.up   = (m_st == M_UP);
        o.down = (m_st == M_DOWN);
        if (pf < 0) o.req = 4'b0001;
        else if (m_st == M_UP) o.req = 4'b0001 << find_above(m_pend, pf);
        else if (m_st == M_DOWN) o.req = 4'b0001 << find_below(m_pend, pf);
        else if (m_st == M_DOOR) o.req = 4'b0001 << m_dfl;
        else o.req = present_floor;
      end
      exp_q.push_back(o);
    end
  end

  // Monitor: compare DUT outputs with the queued expectation away from the edge.
  initial begin
    obs_t o;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        o = exp_q.pop_front();
        if (rst_n) begin
          check("scoreboard", {21'b0, requested_floor, pending, door_open, dir_up, dir_down}, {21'b0, o});
          check("dir_exclusive", {31'b0, dir_up & dir_down}, 32'd0);
        end
      end
    end
  end

  // Advance n clocks; inputs change 2 ns after the edge. Optional random tick
  // and a floor controller that steps one floor toward the request.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      tick = tick_rand ? ($urandom_range(0, 1) == 0) : 1'b0;
      if (plant_en) begin
        pcnt++;
        if (pcnt % 3 == 0 && $onehot(requested_floor) && $onehot(present_floor)
            && requested_floor != present_floor) begin
          if (requested_floor > present_floor) present_floor = present_floor << 1;
          else present_floor = present_floor >> 1;
        end
      end
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
  endtask

  task automatic press(input logic [3:0] b);
    call_btn = b;
    cyc(1);
    call_btn = 4'b0;
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {21'b0, requested_floor, pending, door_open, dir_up, dir_down},
          {21'b0, 4'b0001, 4'b0000, 3'b000});
  endtask

  initial begin
    #12;
    check_reset_vals("reset_state");
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc(5);

    // Serve a call above from floor 0.
    $display("scenario: call floor 2 from floor 0");
    press(4'b0100);
    cyc(2);
    check("r028_pending", {28'b0, pending}, 32'h4);
    cyc(1);
    check("r028_dir_up", {31'b0, dir_up}, 32'd1);
    check("r028_req", {28'b0, requested_floor}, 32'h4);
    present_floor = 4'b0100;
    cyc(1);
    check("r028_door", {31'b0, door_open}, 32'd1);
    repeat (3) pulse_tick();
    check("r028_served", {26'b0, pending, door_open, dir_up}, 32'd0);

    // Dwell restart by a press at the door floor.
    $display("scenario: dwell restart at floor 1");
    present_floor = 4'b0010;
    cyc(1);
    press(4'b0010);
    cyc(3);
    check("r030_door", {31'b0, door_open}, 32'd1);
    repeat (2) pulse_tick();
    press(4'b0010);
    cyc(3);
    repeat (2) pulse_tick();
    check("r030_still_open", {31'b0, door_open}, 32'd1);
    pulse_tick();
    check("r030_closed", {31'b0, door_open}, 32'd0);

    // Calls both sides, last direction up.
    $display("scenario: calls at floor 0 and 3 from floor 1");
    press(4'b1001);
    cyc(2);
    check("r029_pending", {28'b0, pending}, 32'h9);
    cyc(1);
    check("r029_up_first", {27'b0, dir_up, requested_floor}, {27'b0, 1'b1, 4'b1000});
    tick_rand = 1'b1;
    plant_en = 1'b1;
    for (int i = 0; i < 300 && !dir_down; i++) cyc(1);
    check("r029_dir_down", {31'b0, dir_down}, 32'd1);
    check("r029_req_down", {28'b0, requested_floor}, 32'h1);

    // Held button registers once and stays clear after service.
    $display("scenario: hold floor 3 button");
    call_btn = 4'b1000;
    cyc(100);
    check("r031_cleared_held", {31'b0, pending[3]}, 32'd0);
    call_btn = 4'b0;
    tick_rand = 1'b0;
    plant_en = 1'b0;
    cyc(3);

    // Invalid position code.
    $display("scenario: non one-hot present floor");
    present_floor = 4'b0110;
    cyc(5);
    check("r032_invalid", {24'b0, requested_floor, pending, door_open, dir_up, dir_down, 1'b0},
          {24'b0, 4'b0001, 4'b0000, 4'b0000});
    present_floor = 4'b0001;
    cyc(2);

    // Asynchronous reset mid-move, button held through release.
    $display("scenario: reset during upward travel");
    press(4'b1010);
    cyc(3);
    check("r033_moving", {27'b0, dir_up, pending}, {27'b0, 1'b1, 4'b1010});
    call_btn = 4'b0001;
    rst_n = 1'b0;
    #1;
    check_reset_vals("r033_async_reset");
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    check("r025_held_ignored", {28'b0, pending}, 32'h0);
    call_btn = 4'b0;
    cyc(5);
    press(4'b0001);
    cyc(4);

    // Random traffic against the model.
    $display("scenario: random traffic");
    tick_rand = 1'b1;
    plant_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) call_btn = call_btn ^ (4'b0001 << $urandom_range(0, 3));
      cyc(1);
    end
    call_btn = 4'b0;
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
